// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, decoder state encoding, event record and the
// scan-code to ASCII lookup used by the PS/2 key decoder.
package ps2_pkg;

    localparam logic [7:0] SC_E0      = 8'hE0;
    localparam logic [7:0] SC_F0      = 8'hF0;
    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CTRL    = 8'h14;
    localparam logic [7:0] SC_CAPS    = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } ps2_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } ps2_event_t;

    // Set-2 make code to ASCII; ctrl wins over shift/caps for letters.
    function automatic logic [7:0] scan_to_ascii(
        input logic [7:0] code,
        input logic       shift,
        input logic       caps,
        input logic       ctrl
    );
        logic [7:0] ascii;
        logic [4:0] idx;
        logic       is_letter;
        ascii     = '0;
        idx       = '0;
        is_letter = 1'b1;
        case (code)
            8'h1C: idx = 5'd0;   // a
            8'h32: idx = 5'd1;
            8'h21: idx = 5'd2;
            8'h23: idx = 5'd3;
            8'h24: idx = 5'd4;
            8'h2B: idx = 5'd5;
            8'h34: idx = 5'd6;
            8'h33: idx = 5'd7;
            8'h43: idx = 5'd8;
            8'h3B: idx = 5'd9;
            8'h42: idx = 5'd10;
            8'h4B: idx = 5'd11;
            8'h3A: idx = 5'd12;
            8'h31: idx = 5'd13;
            8'h44: idx = 5'd14;
            8'h4D: idx = 5'd15;
            8'h15: idx = 5'd16;
            8'h2D: idx = 5'd17;
            8'h1B: idx = 5'd18;
            8'h2C: idx = 5'd19;
            8'h3C: idx = 5'd20;
            8'h2A: idx = 5'd21;
            8'h1D: idx = 5'd22;
            8'h22: idx = 5'd23;
            8'h35: idx = 5'd24;
            8'h1A: idx = 5'd25;  // z
            default: is_letter = 1'b0;
        endcase
        if (is_letter) begin
            if (ctrl)
                ascii = {3'b000, idx} + 8'd1;
            else if (shift ^ caps)
                ascii = 8'h41 + {3'b000, idx};
            else
                ascii = 8'h61 + {3'b000, idx};
        end else begin
            case (code)
                8'h45: ascii = shift ? 8'h29 : 8'h30;
                8'h16: ascii = shift ? 8'h21 : 8'h31;
                8'h1E: ascii = shift ? 8'h40 : 8'h32;
                8'h26: ascii = shift ? 8'h23 : 8'h33;
                8'h25: ascii = shift ? 8'h24 : 8'h34;
                8'h2E: ascii = shift ? 8'h25 : 8'h35;
                8'h36: ascii = shift ? 8'h5E : 8'h36;
                8'h3D: ascii = shift ? 8'h26 : 8'h37;
                8'h3E: ascii = shift ? 8'h2A : 8'h38;
                8'h46: ascii = shift ? 8'h28 : 8'h39;
                8'h29: ascii = 8'h20;
                8'h5A: ascii = 8'h0D;
                8'h66: ascii = 8'h08;
                8'h0D: ascii = 8'h09;
                default: ascii = 8'h00;
            endcase
        end
        return ascii;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_fifo.sv
// Show-ahead FIFO for decoded key events; head word is zero while empty.
module ps2_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot, so a push into a full queue is taken.
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 scan-code bytes into make/break events with ASCII, tracks
// Shift/Ctrl/Caps state and queues events in a show-ahead FIFO.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kb_code,
    input  logic       kb_ready,
    input  logic       rd_en,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [7:0] ev_ascii,
    output logic       caps_lock,
    output logic       shift_held,
    output logic       ctrl_held,
    output logic [7:0] key_count,
    output logic       overflow
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   byte_strobe;

    ps2_state_t state;
    ps2_state_t next_state;
    logic       ev_fire;
    logic       new_ext;
    logic       new_brk;
    ps2_event_t new_ev;
    ps2_event_t head;

    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic caps_held;
    logic is_shift;
    logic is_ctrl;
    logic is_caps;
    logic fifo_full;
    logic fifo_empty;

    // Reset to 1 so a level already high at reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], kb_ready};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign byte_strobe = sync[SYNC_STAGES-1] & ~prev;

    always_ff @(posedge clk) begin
        if (!clrn)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        ev_fire    = 1'b0;
        new_ext    = 1'b0;
        new_brk    = 1'b0;
        if (byte_strobe) begin
            case (state)
                ST_IDLE: begin
                    if (kb_code == SC_E0)
                        next_state = ST_GOT_E0;
                    else if (kb_code == SC_F0)
                        next_state = ST_GOT_F0;
                    else
                        ev_fire = 1'b1;
                end
                ST_GOT_E0: begin
                    if (kb_code == SC_F0) begin
                        next_state = ST_GOT_E0F0;
                    end else begin
                        ev_fire    = 1'b1;
                        new_ext    = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    ev_fire    = 1'b1;
                    new_brk    = 1'b1;
                    next_state = ST_IDLE;
                end
                ST_GOT_E0F0: begin
                    ev_fire    = 1'b1;
                    new_ext    = 1'b1;
                    new_brk    = 1'b1;
                    next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        new_ev.code  = kb_code;
        new_ev.ext   = new_ext;
        new_ev.brk   = new_brk;
        new_ev.ascii = (new_ext || new_brk) ? 8'h00
                     : scan_to_ascii(kb_code, shift_held, caps_lock, ctrl_held);
    end

    assign is_shift = ~new_ext & ((kb_code == SC_LSHIFT) | (kb_code == SC_RSHIFT));
    assign is_ctrl  = (kb_code == SC_CTRL);
    assign is_caps  = ~new_ext & (kb_code == SC_CAPS);

    // Side state updates on the FIFO write edge, after ASCII used the old values.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            lctrl     <= 1'b0;
            rctrl     <= 1'b0;
            caps_held <= 1'b0;
            caps_lock <= 1'b0;
            key_count <= '0;
            overflow  <= 1'b0;
        end else if (ev_fire) begin
            if (is_shift && kb_code == SC_LSHIFT)
                lshift <= ~new_brk;
            if (is_shift && kb_code == SC_RSHIFT)
                rshift <= ~new_brk;
            if (is_ctrl && !new_ext)
                lctrl <= ~new_brk;
            if (is_ctrl && new_ext)
                rctrl <= ~new_brk;
            if (is_caps) begin
                if (new_brk) begin
                    caps_held <= 1'b0;
                end else if (!caps_held) begin
                    caps_held <= 1'b1;
                    caps_lock <= ~caps_lock;
                end
            end
            if (!new_brk && !is_shift && !is_ctrl && !is_caps)
                key_count <= key_count + 8'd1;
            if (fifo_full && !rd_en)
                overflow <= 1'b1;
        end
    end

    assign shift_held = lshift | rshift;
    assign ctrl_held  = lctrl | rctrl;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_event_t))
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (ev_fire),
        .wdata (new_ev),
        .pop   (rd_en),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev_valid = ~fifo_empty;
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_break = head.brk;
    assign ev_ascii = head.ascii;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder (depth 8, 2 sync stages).
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] kb_code;
    logic       kb_ready;
    logic       rd_en;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [7:0] ev_ascii;
    logic       caps_lock;
    logic       shift_held;
    logic       ctrl_held;
    logic [7:0] key_count;
    logic       overflow;
    logic [17:0] head;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FIFO_DEPTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .kb_code    (kb_code),
        .kb_ready   (kb_ready),
        .rd_en      (rd_en),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_ascii   (ev_ascii),
        .caps_lock  (caps_lock),
        .shift_held (shift_held),
        .ctrl_held  (ctrl_held),
        .key_count  (key_count),
        .overflow   (overflow)
    );

    assign head = {ev_code, ev_ext, ev_break, ev_ascii};

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] c);
        @(negedge clk);
        kb_code  = c;
        kb_ready = 1'b1;
        repeat (4) @(negedge clk);
        kb_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [30:0] outs;
        do_reset();
        outs = {ev_valid, ev_code, ev_ext, ev_break, ev_ascii, caps_lock,
                shift_held, ctrl_held, key_count, overflow};
        checks++;
        if (outs !== 31'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
    endtask

    task automatic test_basic();
        do_reset();
        @(negedge clk);
        kb_code  = 8'h1C;
        kb_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early got=%b exp=0", ev_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ev_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency_edge got=%b exp=1", ev_valid);
        end
        repeat (3) @(negedge clk);
        kb_ready = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if (head !== {8'h1C, 1'b0, 1'b0, 8'h61}) begin
            failures++;
            $display("FAIL basic_make got=%h exp=%h", head, {8'h1C, 2'b00, 8'h61});
        end
        pop_one();
        checks++;
        if (head !== {8'h1C, 1'b0, 1'b1, 8'h00} || ev_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_break got=%h v=%b exp=%h", head, ev_valid, {8'h1C, 2'b01, 8'h00});
        end
        pop_one();
        checks++;
        if (ev_valid !== 1'b0 || key_count !== 8'd1) begin
            failures++;
            $display("FAIL basic_tail got v=%b kc=%0d exp v=0 kc=1", ev_valid, key_count);
        end
    endtask

    task automatic test_shift();
        logic [17:0] exp [4] = '{{8'h12, 2'b00, 8'h00}, {8'h1C, 2'b00, 8'h41},
                                 {8'h1C, 2'b01, 8'h00}, {8'h12, 2'b01, 8'h00}};
        do_reset();
        send_byte(8'h12);
        checks++;
        if (shift_held !== 1'b1) begin
            failures++;
            $display("FAIL shift_set got=%b exp=1", shift_held);
        end
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h12);
        checks++;
        if (shift_held !== 1'b0 || key_count !== 8'd1) begin
            failures++;
            $display("FAIL shift_clear got sh=%b kc=%0d exp sh=0 kc=1", shift_held, key_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || head !== exp[i]) begin
                failures++;
                $display("FAIL shift_ev%0d got=%h v=%b exp=%h", i, head, ev_valid, exp[i]);
            end
            pop_one();
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL shift_empty got=%b exp=0", ev_valid);
        end
    endtask

    task automatic test_caps();
        logic [17:0] exp [6] = '{{8'h58, 2'b00, 8'h00}, {8'h58, 2'b00, 8'h00},
                                 {8'h58, 2'b01, 8'h00}, {8'h1C, 2'b00, 8'h41},
                                 {8'h58, 2'b00, 8'h00}, {8'h1C, 2'b00, 8'h61}};
        do_reset();
        send_byte(8'h58);
        checks++;
        if (caps_lock !== 1'b1) begin
            failures++;
            $display("FAIL caps_first got=%b exp=1", caps_lock);
        end
        send_byte(8'h58);
        checks++;
        if (caps_lock !== 1'b1) begin
            failures++;
            $display("FAIL caps_repeat got=%b exp=1", caps_lock);
        end
        send_byte(8'hF0);
        send_byte(8'h58);
        checks++;
        if (caps_lock !== 1'b1) begin
            failures++;
            $display("FAIL caps_break got=%b exp=1", caps_lock);
        end
        send_byte(8'h1C);
        send_byte(8'h58);
        checks++;
        if (caps_lock !== 1'b0) begin
            failures++;
            $display("FAIL caps_off got=%b exp=0", caps_lock);
        end
        send_byte(8'h1C);
        checks++;
        if (key_count !== 8'd2) begin
            failures++;
            $display("FAIL caps_count got=%0d exp=2", key_count);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || head !== exp[i]) begin
                failures++;
                $display("FAIL caps_ev%0d got=%h v=%b exp=%h", i, head, ev_valid, exp[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_ext();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++;
        if (head !== {8'h75, 2'b10, 8'h00}) begin
            failures++;
            $display("FAIL ext_make got=%h exp=%h", head, {8'h75, 2'b10, 8'h00});
        end
        pop_one();
        checks++;
        if (head !== {8'h75, 2'b11, 8'h00} || ev_valid !== 1'b1) begin
            failures++;
            $display("FAIL ext_break got=%h v=%b exp=%h", head, ev_valid, {8'h75, 2'b11, 8'h00});
        end
        pop_one();
        checks++;
        if (ev_valid !== 1'b0 || key_count !== 8'd1) begin
            failures++;
            $display("FAIL ext_tail got v=%b kc=%0d exp v=0 kc=1", ev_valid, key_count);
        end
    endtask

    task automatic test_ctrl_digits();
        logic [17:0] exp [8] = '{{8'h14, 2'b10, 8'h00}, {8'h1C, 2'b00, 8'h01},
                                 {8'h14, 2'b11, 8'h00}, {8'h12, 2'b00, 8'h00},
                                 {8'h16, 2'b00, 8'h21}, {8'h12, 2'b01, 8'h00},
                                 {8'h16, 2'b00, 8'h31}, {8'h29, 2'b00, 8'h20}};
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h14);
        checks++;
        if (ctrl_held !== 1'b1) begin
            failures++;
            $display("FAIL ctrl_set got=%b exp=1", ctrl_held);
        end
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h14);
        checks++;
        if (ctrl_held !== 1'b0) begin
            failures++;
            $display("FAIL ctrl_clear got=%b exp=0", ctrl_held);
        end
        send_byte(8'h12);
        send_byte(8'h16);
        send_byte(8'hF0);
        send_byte(8'h12);
        send_byte(8'h16);
        send_byte(8'h29);
        checks++;
        if (key_count !== 8'd4) begin
            failures++;
            $display("FAIL ctrl_count got=%0d exp=4", key_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || head !== exp[i]) begin
                failures++;
                $display("FAIL ctrl_ev%0d got=%h v=%b exp=%h", i, head, ev_valid, exp[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                                   8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
        logic [7:0] chars [10] = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74,
                                   8'h79, 8'h75, 8'h69, 8'h6F, 8'h70};
        do_reset();
        for (int i = 0; i < 9; i++)
            send_byte(codes[i]);
        checks++;
        if (ev_valid !== 1'b1 || overflow !== 1'b1 || key_count !== 8'd9) begin
            failures++;
            $display("FAIL ovf_flags got v=%b ovf=%b kc=%0d exp v=1 ovf=1 kc=9", ev_valid, overflow, key_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || head !== {codes[i], 2'b00, chars[i]}) begin
                failures++;
                $display("FAIL ovf_ev%0d got=%h v=%b exp=%h", i, head, ev_valid, {codes[i], 2'b00, chars[i]});
            end
            pop_one();
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain got=%b exp=0", ev_valid);
        end

        do_reset();
        for (int i = 0; i < 8; i++)
            send_byte(codes[i]);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_no_ovf got=%b exp=0", overflow);
        end
        @(negedge clk);
        kb_code  = codes[8];
        kb_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        kb_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || key_count !== 8'd9) begin
            failures++;
            $display("FAIL poppush_flags got ovf=%b kc=%0d exp ovf=0 kc=9", overflow, key_count);
        end
        for (int i = 1; i < 9; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || head !== {codes[i], 2'b00, chars[i]}) begin
                failures++;
                $display("FAIL poppush_ev%0d got=%h v=%b exp=%h", i, head, ev_valid, {codes[i], 2'b00, chars[i]});
            end
            pop_one();
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL poppush_drain got=%b exp=0", ev_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h1C);
        checks++;
        if (ev_valid !== 1'b1 || head !== {8'h1C, 2'b00, 8'h61}) begin
            failures++;
            $display("FAIL midreset_ev got=%h v=%b exp=%h", head, ev_valid, {8'h1C, 2'b00, 8'h61});
        end
        @(negedge clk);
        kb_code  = 8'h1C;
        kb_ready = 1'b1;
        do_reset();
        repeat (6) @(negedge clk);
        checks++;
        if (ev_valid !== 1'b0 || key_count !== 8'd0) begin
            failures++;
            $display("FAIL held_ready got v=%b kc=%0d exp v=0 kc=0", ev_valid, key_count);
        end
        kb_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        clrn     = 1'b0;
        kb_code  = 8'h00;
        kb_ready = 1'b0;
        rd_en    = 1'b0;
        test_reset();
        test_basic();
        test_shift();
        test_caps();
        test_ext();
        test_ctrl_digits();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
